// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - shared opcodes, IR state encoding and default widths
// Purpose: constants and types shared by ir_fifo and ir_decode_queue.
package ir_pkg;

  // Default geometry of the instruction path
  localparam int IW_DEF    = 8;
  localparam int OPW_DEF   = 3;
  localparam int NOPS_DEF  = 7;
  localparam int DEPTH_DEF = 2;

  // Opcode field values (low OPW bits of the instruction word)
  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_STO  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  // Instruction register state
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } ir_state_e;

endpackage

// File: rtl/ir_fifo.sv
// rtl/ir_fifo.sv - prefetch queue in front of the instruction register
// Purpose: DEPTH x IW circular buffer with push/pop/flush.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         write push_data at the tail (caller guarantees !full)
//   push_data    instruction word to enqueue
//   pop          drop the head entry (caller guarantees !empty)
//   flush        discard all entries; wins over push and pop
//   head         current head entry (valid while !empty)
//   full, empty  occupancy flags from registered count only
module ir_fifo
  import ir_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [IW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [IW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ir_decode_queue.sv
// rtl/ir_decode_queue.sv - queued instruction register with one-hot decode
// Purpose: accepts fetched instructions into a prefetch queue, loads the
// head into the IR, decodes it and holds it until the controller issues it.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    fetch presents in_instr
//   in_ready    queue can take an instruction (registered state only)
//   in_instr    fetched instruction word
//   issue       controller retires the decoded instruction
//   flush       drop queue and IR contents (IR kept while halted)
//   dec_valid   IR holds a decoded instruction
//   op_onehot   one-hot opcode, bit k for opcode k
//   operand     in_instr[IW-1:OPW] of the IR instruction
//   illegal     IR opcode is outside 0..NOPS-1
//   halted      HALT opcode has been loaded; cleared only by rst
module ir_decode_queue
  import ir_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int NOPS  = NOPS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_instr,
  input  logic              issue,
  input  logic              flush,
  output logic              dec_valid,
  output logic [NOPS-1:0]   op_onehot,
  output logic [IW-OPW-1:0] operand,
  output logic              illegal,
  output logic              halted
);

  ir_state_e state_q;
  ir_state_e state_d;

  logic          push;
  logic          pop;
  logic          load;
  logic          clear;
  logic          full;
  logic          empty;
  logic [IW-1:0] head;

  logic [OPW-1:0]  head_op;
  logic [NOPS-1:0] dec_onehot;
  logic            dec_illegal;
  logic            head_is_halt;

  assign halted    = (state_q == ST_HALT);
  assign dec_valid = (state_q != ST_EMPTY);
  assign in_ready  = !full && !halted;
  assign push      = in_valid && in_ready && !flush;

  ir_fifo #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_instr),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Decode the queue head so the IR captures the result as it loads.
  assign head_op      = head[OPW-1:0];
  assign dec_illegal  = (int'(head_op) >= NOPS);
  assign head_is_halt = (int'(head_op) == NOPS - 1);

  always_comb begin
    dec_onehot = '0;
    for (int k = 0; k < NOPS; k++) begin
      dec_onehot[k] = (int'(head_op) == k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // load: pop the head into the IR. clear: IR becomes empty.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    pop     = 1'b0;
    if (flush) begin
      // A halted IR survives flush; only the queue is emptied.
      if (state_q != ST_HALT) begin
        state_d = ST_EMPTY;
        clear   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (!empty) begin
            load = 1'b1;
          end
        end
        ST_VALID: begin
          if (issue) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_EMPTY;
              clear   = 1'b1;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_EMPTY;
          clear   = 1'b1;
        end
      endcase
      if (load) begin
        pop     = 1'b1;
        state_d = head_is_halt ? ST_HALT : ST_VALID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      op_onehot <= '0;
      operand   <= '0;
      illegal   <= 1'b0;
    end else if (load) begin
      op_onehot <= dec_onehot;
      operand   <= head[IW-1:OPW];
      illegal   <= dec_illegal;
    end
  end

endmodule
